// File: rtl/legv8_ctrl_pkg.sv
// Shared constants for the LEGv8 multi-cycle controller: opcode patterns,
// instruction classes, FSM state encoding and ALU/extender selects.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_IMM,
        CL_MOVZ,
        CL_B,
        CL_CBZ,
        CL_LDUR,
        CL_STUR,
        CL_ILL
    } class_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [2:0] SEXT_I    = 3'b000;
    localparam logic [2:0] SEXT_D    = 3'b001;
    localparam logic [2:0] SEXT_B    = 3'b010;
    localparam logic [2:0] SEXT_CBZ  = 3'b011;
    localparam logic [2:0] SEXT_MOVZ = 3'b100;

    // '?' bits are don't-cares when matched with casez
    localparam logic [10:0] OP_ANDREG = 11'b10001010000;
    localparam logic [10:0] OP_ORRREG = 11'b10101010000;
    localparam logic [10:0] OP_ADDREG = 11'b10001011000;
    localparam logic [10:0] OP_SUBREG = 11'b11001011000;
    localparam logic [10:0] OP_ADDIMM = 11'b1001000100?;
    localparam logic [10:0] OP_SUBIMM = 11'b1101000100?;
    localparam logic [10:0] OP_ANDIMM = 11'b1001001000?;
    localparam logic [10:0] OP_ORRIMM = 11'b1011001000?;
    localparam logic [10:0] OP_MOVZ   = 11'b110100101??;
    localparam logic [10:0] OP_B      = 11'b000101?????;
    localparam logic [10:0] OP_CBZ    = 11'b10110100???;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decoder: maps IR[31:21] to an instruction class plus
// the ALU operation and immediate-extender mode that class uses in EXEC.
module opcode_classifier
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output class_t      o_class,
    output logic [3:0]  o_aluop,
    output logic [2:0]  o_signop
);

    always_comb begin
        o_class  = CL_ILL;
        o_aluop  = ALU_AND;
        o_signop = SEXT_I;
        casez (i_opcode)
            OP_ADDREG: begin o_class = CL_RTYPE; o_aluop = ALU_ADD; end
            OP_SUBREG: begin o_class = CL_RTYPE; o_aluop = ALU_SUB; end
            OP_ANDREG: begin o_class = CL_RTYPE; o_aluop = ALU_AND; end
            OP_ORRREG: begin o_class = CL_RTYPE; o_aluop = ALU_ORR; end
            OP_ADDIMM: begin o_class = CL_IMM;   o_aluop = ALU_ADD; end
            OP_SUBIMM: begin o_class = CL_IMM;   o_aluop = ALU_SUB; end
            OP_ANDIMM: begin o_class = CL_IMM;   o_aluop = ALU_AND; end
            OP_ORRIMM: begin o_class = CL_IMM;   o_aluop = ALU_ORR; end
            OP_MOVZ: begin
                o_class  = CL_MOVZ;
                o_aluop  = ALU_PASSB;
                o_signop = SEXT_MOVZ;
            end
            OP_B: begin
                o_class  = CL_B;
                o_signop = SEXT_B;
            end
            // CBZ tests the Rt value, routed to ALU input B
            OP_CBZ: begin
                o_class  = CL_CBZ;
                o_aluop  = ALU_PASSB;
                o_signop = SEXT_CBZ;
            end
            OP_LDUR: begin o_class = CL_LDUR; o_aluop = ALU_ADD; o_signop = SEXT_D; end
            OP_STUR: begin o_class = CL_STUR; o_aluop = ALU_ADD; o_signop = SEXT_D; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR) with
// ready handshakes, wait timeout, and optional perf counters under PERF_CNT_EN.
module multicycle_sequencer
    import legv8_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
)
(
    input  logic             CLK,
    input  logic             resetl,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             memread,
    output logic             memwrite,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic [3:0]       aluop,
    output logic [2:0]       signop,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    class_t     r_class;
    logic [3:0] r_aluop;
    logic [2:0] r_signop;
    logic [7:0] r_wait;

    class_t     w_class;
    logic [3:0] w_aluop;
    logic [2:0] w_signop;
    logic       w_waiting;
    logic       w_ready;
    logic       w_timeout;
    logic       w_alusrc;

    opcode_classifier u_classifier (
        .i_opcode (opcode),
        .o_class  (w_class),
        .o_aluop  (w_aluop),
        .o_signop (w_signop)
    );

    assign w_waiting = (r_state == FETCH) || (r_state == MEM);
    assign w_ready   = (r_state == FETCH) ? imem_ready : dmem_ready;
    assign w_timeout = (r_wait == WAIT_LAST);
    assign w_alusrc  = (r_class == CL_IMM) || (r_class == CL_MOVZ) ||
                       (r_class == CL_LDUR) || (r_class == CL_STUR);

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (imem_ready)     w_next_state = DECODE;
                else if (w_timeout) w_next_state = ERR;
            end
            DECODE: w_next_state = (w_class == CL_ILL) ? ERR : EXEC;
            EXEC: begin
                case (r_class)
                    CL_RTYPE, CL_IMM, CL_MOVZ: w_next_state = WB;
                    CL_LDUR, CL_STUR:          w_next_state = MEM;
                    CL_B, CL_CBZ:              w_next_state = FETCH;
                    default:                   w_next_state = ERR;
                endcase
            end
            MEM: begin
                if (dmem_ready)     w_next_state = (r_class == CL_LDUR) ? WB : FETCH;
                else if (w_timeout) w_next_state = ERR;
            end
            WB:      w_next_state = FETCH;
            ERR:     w_next_state = ERR;
            default: w_next_state = ERR;
        endcase
    end

    // Wait counter restarts on ready or any state change; class is latched on leaving DECODE
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_wait   <= 8'd0;
            r_class  <= CL_ILL;
            r_aluop  <= ALU_AND;
            r_signop <= SEXT_I;
        end else begin
            if (w_waiting && !w_ready && (w_next_state == r_state)) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (r_state == DECODE) begin
                r_class  <= w_class;
                r_aluop  <= w_aluop;
                r_signop <= w_signop;
            end
        end
    end

    always_comb begin
        imem_req = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        aluop    = 4'b0000;
        signop   = 3'b000;
        state    = FETCH;
        err      = 1'b0;
        if (resetl) begin
            state = r_state;
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                DECODE: reg2loc = (w_class == CL_CBZ) || (w_class == CL_STUR);
                EXEC: begin
                    alusrc = w_alusrc;
                    aluop  = r_aluop;
                    signop = r_signop;
                    if (r_class == CL_B) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end else if (r_class == CL_CBZ) begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                end
                MEM: begin
                    alusrc   = w_alusrc;
                    aluop    = r_aluop;
                    signop   = r_signop;
                    memread  = (r_class == CL_LDUR);
                    memwrite = (r_class == CL_STUR);
                    pc_write = dmem_ready && (r_class == CL_STUR);
                end
                WB: begin
                    regwrite = 1'b1;
                    mem2reg  = (r_class == CL_LDUR);
                    pc_write = 1'b1;
                end
                ERR:     err = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ERR) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (pc_write)       r_instret_cnt <= r_instret_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus random
// instruction/ready streams checked against a per-instruction behavioural model.
module tb_multicycle_sequencer;

    localparam int TO = 12;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd7;

    // kind: 0 ALU-to-WB, 1 B, 2 CBZ, 3 LDUR, 4 STUR
    localparam int NOPS = 13;
    localparam logic [10:0] OP_BASE [NOPS] = '{
        11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
        11'b10010001000, 11'b11010001000, 11'b10010010000, 11'b10110010000,
        11'b11010010100, 11'b00010100000, 11'b10110100000, 11'b11111000010,
        11'b11111000000};
    localparam logic [10:0] OP_MASK [NOPS] = '{
        11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd1,
        11'd3, 11'd31, 11'd7, 11'd0, 11'd0};
    localparam logic [3:0] EXP_ALU [NOPS] = '{
        4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
        4'b0111, 4'b0000, 4'b0111, 4'b0010, 4'b0010};
    localparam logic [2:0] EXP_SEXT [NOPS] = '{
        3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
        3'b100, 3'b010, 3'b011, 3'b001, 3'b001};
    localparam logic EXP_ASRC [NOPS] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam int KIND [NOPS] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4};

    logic        CLK;
    logic        resetl;
    logic [10:0] opcode;
    logic        zero, imem_ready, dmem_ready;
    logic        imem_req, memread, memwrite, ir_write, pc_write, pc_src;
    logic        reg2loc, alusrc, mem2reg, regwrite, err;
    logic [3:0]  aluop;
    logic [2:0]  signop, state;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [20:0] obsVec;

    int checks = 0;
    int failures = 0;
    int expCycles = 0;
    int expInstret = 0;

    multicycle_sequencer #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .opcode      (opcode),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .memread     (memread),
        .memwrite    (memwrite),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg2loc     (reg2loc),
        .alusrc      (alusrc),
        .mem2reg     (mem2reg),
        .regwrite    (regwrite),
        .aluop       (aluop),
        .signop      (signop),
        .state       (state),
        .err         (err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    assign obsVec = {imem_req, memread, memwrite, ir_write, pc_write, pc_src, reg2loc,
                     alusrc, mem2reg, regwrite, aluop, signop, state, err};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [20:0] ev(input logic [2:0] st, input logic imr, input logic mr,
                                       input logic mw, input logic irw, input logic pcw,
                                       input logic pcs, input logic r2l, input logic asrc,
                                       input logic m2r, input logic rw, input logic [3:0] aop,
                                       input logic [2:0] sop, input logic e);
        return {imr, mr, mw, irw, pcw, pcs, r2l, asrc, m2r, rw, aop, sop, st, e};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input logic imr, input logic dmr, input logic z);
        imem_ready = imr;
        dmem_ready = dmr;
        zero       = z;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle(input logic imr, input logic dmr, input logic z,
                             input logic [20:0] expVec, input string tag);
        applyStimulus(imr, dmr, z);
        checkOutput(tag, 32'(obsVec), 32'(expVec));
        @(posedge CLK);
        #1;
    endtask

    task automatic checkCounters(input string tag);
`ifdef PERF_CNT_EN
        checkOutput({tag, "_cycles"}, cycle_cnt, 32'(expCycles));
        checkOutput({tag, "_instret"}, instret_cnt, 32'(expInstret));
`else
        checkOutput({tag, "_cycles"}, cycle_cnt, 32'd0);
        checkOutput({tag, "_instret"}, instret_cnt, 32'd0);
`endif
    endtask

    task automatic doReset();
        resetl = 1'b0;
        for (int i = 0; i < 2; i++) stepCycle(rb(), rb(), rb(), 21'd0, "reset_outputs");
        expCycles  = 0;
        expInstret = 0;
        checkCounters("reset");
        resetl = 1'b1;
    endtask

    // One instruction: fw fetch waits, mw memory waits, zv on zero during EXEC
    task automatic runInstr(input int idx, input int fw, input int mw, input logic zv,
                            input bit abortInMem);
        int   k;
        logic isMem;
        k      = KIND[idx];
        isMem  = (k == 3) || (k == 4);
        opcode = OP_BASE[idx] | (11'($urandom) & OP_MASK[idx]);
        for (int i = 0; i < fw; i++)
            stepCycle(1'b0, rb(), rb(), ev(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0),
                      "fetch_wait");
        stepCycle(1'b1, rb(), rb(), ev(ST_FETCH, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0),
                  "fetch_done");
        stepCycle(rb(), rb(), rb(), ev(ST_DECODE, 0, 0, 0, 0, 0, 0, (k == 2) || (k == 4),
                  0, 0, 0, 4'd0, 3'd0, 0), "decode");
        stepCycle(rb(), rb(), zv, ev(ST_EXEC, 0, 0, 0, 0, (k == 1) || (k == 2),
                  (k == 1) || ((k == 2) && zv), 0, EXP_ASRC[idx], 0, 0, EXP_ALU[idx],
                  EXP_SEXT[idx], 0), "exec");
        if (isMem) begin
            for (int i = 0; i < mw; i++)
                stepCycle(rb(), 1'b0, rb(), ev(ST_MEM, 0, k == 3, k == 4, 0, 0, 0, 0,
                          EXP_ASRC[idx], 0, 0, EXP_ALU[idx], EXP_SEXT[idx], 0), "mem_wait");
            if (abortInMem) return;
            stepCycle(rb(), 1'b1, rb(), ev(ST_MEM, 0, k == 3, k == 4, 0, k == 4, 0, 0,
                      EXP_ASRC[idx], 0, 0, EXP_ALU[idx], EXP_SEXT[idx], 0), "mem_done");
        end
        if ((k == 0) || (k == 3))
            stepCycle(rb(), rb(), rb(), ev(ST_WB, 0, 0, 0, 0, 1, 0, 0, 0, k == 3, 1,
                      4'd0, 3'd0, 0), "writeback");
        case (k)
            1, 2:    expCycles += 3 + fw;
            3:       expCycles += 5 + fw + mw;
            4:       expCycles += 4 + fw + mw;
            default: expCycles += 4 + fw;
        endcase
        expInstret++;
        checkOutput("back_to_fetch", 32'(state), 32'(ST_FETCH));
        checkCounters("instr");
    endtask

    initial begin
        resetl     = 1'b0;
        opcode     = 11'd0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        doReset();

        $display("[TB] ADD, LDUR with waits, CBZ taken/not taken, B, STUR");
        runInstr(0, 0, 0, 1'b0, 1'b0);
        runInstr(11, 0, 3, 1'b0, 1'b0);
        runInstr(10, 0, 0, 1'b1, 1'b0);
        runInstr(10, 0, 0, 1'b0, 1'b0);
        runInstr(9, 2, 0, 1'b0, 1'b0);
        runInstr(12, 1, 0, 1'b0, 1'b0);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 40; n++)
            runInstr($urandom_range(0, NOPS - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                     rb(), 1'b0);

        $display("[TB] illegal opcode");
        opcode = 11'd0;
        stepCycle(1'b1, rb(), rb(), ev(ST_FETCH, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0),
                  "ill_fetch");
        stepCycle(rb(), rb(), rb(), ev(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0),
                  "ill_decode");
        expCycles += 2;
        for (int i = 0; i < 100; i++)
            stepCycle(rb(), rb(), rb(), ev(ST_ERR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 1),
                      "ill_err_hold");
        checkCounters("ill");
        doReset();

        $display("[TB] fetch timeout");
        opcode = 11'b10001011000;
        for (int i = 0; i < TO; i++)
            stepCycle(1'b0, rb(), rb(), ev(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 0),
                      "timeout_wait");
        expCycles += TO;
        stepCycle(rb(), rb(), rb(), ev(ST_ERR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 1),
                  "timeout_err");
        checkCounters("timeout");
        doReset();

        $display("[TB] ready on the last allowed cycle");
        runInstr(0, TO - 1, 0, 1'b0, 1'b0);

        $display("[TB] reset during STUR memory phase");
        runInstr(12, 0, 2, 1'b0, 1'b1);
        doReset();
        runInstr(1, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
